// File: rtl/hazard_fwd_ctrl.sv
// Forwarding and load-use hazard controller for the five-stage pipeline.
// Picks the nearest valid producer per operand and holds load-use stalls for LOAD_LAT cycles.
module hazard_fwd_ctrl #(
   parameter int AW       = 5,
   parameter int NSTG     = 3,
   parameter int LOAD_LAT = 1,
   parameter int CNT_W    = 32,
   parameter int SW       = $clog2(NSTG+1)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                id_valid,
   input  logic [AW-1:0]       id_ra,
   input  logic [AW-1:0]       id_rb,
   input  logic                id_use_a,
   input  logic                id_use_b,
   input  logic [NSTG*AW-1:0]  stg_rw,
   input  logic [NSTG-1:0]     stg_we,
   input  logic [NSTG-1:0]     stg_is_load,
   input  logic                flush,
   input  logic                cnt_clr,
   output logic [SW-1:0]       fwd_a_sel,
   output logic [SW-1:0]       fwd_b_sel,
   output logic                stall,
   output logic                bubble,
   output logic [CNT_W-1:0]    stall_cnt,
   output logic [CNT_W-1:0]    fwd_cnt
);

   localparam int RW = $clog2(LOAD_LAT+1);

   typedef enum logic {S_IDLE, S_HOLD} state_t;

   state_t            r_state, w_state_next;
   logic [RW-1:0]     r_rem, w_rem_next;
   logic [NSTG-1:0]   w_match_a, w_match_b;
   logic [SW-1:0]     w_sel_a, w_sel_b;
   logic              w_hazard;
   logic              w_fwd_inc;
   logic [CNT_W-1:0]  r_stall_cnt, r_fwd_cnt;
   logic              w_unused;

   // Register 0 is hard-wired to zero, so it is never a forwarding source.
   generate
      for (genvar gi = 0; gi < NSTG; gi++) begin : g_match
         assign w_match_a[gi] = id_valid && id_use_a && stg_we[gi] &&
                                (stg_rw[gi*AW +: AW] == id_ra) && (id_ra != '0);
         assign w_match_b[gi] = id_valid && id_use_b && stg_we[gi] &&
                                (stg_rw[gi*AW +: AW] == id_rb) && (id_rb != '0);
      end
   endgenerate

   // Scan oldest to nearest so the nearest matching stage overwrites older ones.
   always_comb begin
      w_sel_a = '0;
      w_sel_b = '0;
      for (int k = NSTG-1; k >= 0; k--) begin
         if (w_match_a[k]) w_sel_a = SW'(k+1);
         if (w_match_b[k]) w_sel_b = SW'(k+1);
      end
   end

   assign w_hazard = stg_is_load[0] && ((w_sel_a == SW'(1)) || (w_sel_b == SW'(1)));
   assign w_unused = ^stg_is_load;

   always_comb begin
      w_state_next = r_state;
      w_rem_next   = r_rem;
      stall        = 1'b0;
      bubble       = 1'b0;
      if (flush) begin
         bubble       = 1'b1;
         w_state_next = S_IDLE;
         w_rem_next   = '0;
      end else if (r_state == S_HOLD) begin
         stall      = 1'b1;
         bubble     = 1'b1;
         w_rem_next = r_rem - RW'(1);
         if (r_rem == RW'(1)) w_state_next = S_IDLE;
      end else if (w_hazard) begin
         stall  = 1'b1;
         bubble = 1'b1;
         if (LOAD_LAT > 1) begin
            w_state_next = S_HOLD;
            w_rem_next   = RW'(LOAD_LAT-1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_rem   <= '0;
      end else begin
         r_state <= w_state_next;
         r_rem   <= w_rem_next;
      end
   end

   assign w_fwd_inc = id_valid && !stall && !flush && ((w_sel_a != '0) || (w_sel_b != '0));

   always_ff @(posedge clk) begin
      if (rst || cnt_clr) begin
         r_stall_cnt <= '0;
         r_fwd_cnt   <= '0;
      end else begin
         if (stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         if (w_fwd_inc && (r_fwd_cnt != '1)) r_fwd_cnt <= r_fwd_cnt + CNT_W'(1);
      end
   end

   assign fwd_a_sel = w_sel_a;
   assign fwd_b_sel = w_sel_b;
   assign stall_cnt = r_stall_cnt;
   assign fwd_cnt   = r_fwd_cnt;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Bench for hazard_fwd_ctrl: one instance with LOAD_LAT=1/CNT_W=32, one with LOAD_LAT=3/CNT_W=4,
// sharing stimulus; expected outputs go through a scoreboard queue and are compared at negedge.
module tb_hazard_fwd_ctrl;

   logic        clk = 1'b0;
   logic        rst, id_valid, id_use_a, id_use_b, flush, cnt_clr;
   logic [4:0]  id_ra, id_rb;
   logic [14:0] stg_rw;
   logic [2:0]  stg_we, stg_is_load;

   logic [1:0]  d1_a, d1_b, d3_a, d3_b;
   logic        d1_st, d1_bu, d3_st, d3_bu;
   logic [31:0] d1_scnt, d1_fcnt;
   logic [3:0]  d3_scnt, d3_fcnt;

   int n_checks = 0;
   int n_fail   = 0;
   logic use3 = 1'b0;

   always #5 clk = ~clk;

   hazard_fwd_ctrl #(.AW(5), .NSTG(3), .LOAD_LAT(1), .CNT_W(32)) dut1 (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_ra(id_ra), .id_rb(id_rb),
      .id_use_a(id_use_a), .id_use_b(id_use_b), .stg_rw(stg_rw), .stg_we(stg_we),
      .stg_is_load(stg_is_load), .flush(flush), .cnt_clr(cnt_clr),
      .fwd_a_sel(d1_a), .fwd_b_sel(d1_b), .stall(d1_st), .bubble(d1_bu),
      .stall_cnt(d1_scnt), .fwd_cnt(d1_fcnt));

   hazard_fwd_ctrl #(.AW(5), .NSTG(3), .LOAD_LAT(3), .CNT_W(4)) dut3 (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_ra(id_ra), .id_rb(id_rb),
      .id_use_a(id_use_a), .id_use_b(id_use_b), .stg_rw(stg_rw), .stg_we(stg_we),
      .stg_is_load(stg_is_load), .flush(flush), .cnt_clr(cnt_clr),
      .fwd_a_sel(d3_a), .fwd_b_sel(d3_b), .stall(d3_st), .bubble(d3_bu),
      .stall_cnt(d3_scnt), .fwd_cnt(d3_fcnt));

   logic [5:0]  o_vec;
   logic [31:0] o_scnt, o_fcnt;
   assign o_vec  = use3 ? {d3_a, d3_b, d3_st, d3_bu} : {d1_a, d1_b, d1_st, d1_bu};
   assign o_scnt = use3 ? {28'd0, d3_scnt} : d1_scnt;
   assign o_fcnt = use3 ? {28'd0, d3_fcnt} : d1_fcnt;

   typedef struct packed {
      logic       v;
      logic [4:0] ra;
      logic       ua;
      logic [4:0] rb;
      logic       ub;
      logic [4:0] r2, r1, r0;
      logic [2:0] we, ld;
      logic       fl, clr, rs;
      logic [5:0] xp;
   } step_t;

   logic [5:0] sbq[$];

   function automatic step_t mk(input logic v, input logic [4:0] ra, input logic ua,
                                input logic [4:0] rb, input logic ub,
                                input logic [4:0] r2, r1, r0, input logic [2:0] we, ld,
                                input logic fl, clr, rs, input logic [1:0] xa, xb,
                                input logic xs, xbu);
      step_t s;
      s.v = v; s.ra = ra; s.ua = ua; s.rb = rb; s.ub = ub;
      s.r2 = r2; s.r1 = r1; s.r0 = r0; s.we = we; s.ld = ld;
      s.fl = fl; s.clr = clr; s.rs = rs; s.xp = {xa, xb, xs, xbu};
      return s;
   endfunction

   // Drives one cycle of stimulus and records what the DUT must show for it.
   task automatic apply(input step_t s);
      id_valid = s.v; id_ra = s.ra; id_use_a = s.ua; id_rb = s.rb; id_use_b = s.ub;
      stg_rw = {s.r2, s.r1, s.r0}; stg_we = s.we; stg_is_load = s.ld;
      flush = s.fl; cnt_clr = s.clr; rst = s.rs;
      sbq.push_back(s.xp);
   endtask

   task automatic do_reset();
      rst = 1'b1; id_valid = 1'b0; flush = 1'b0; cnt_clr = 1'b0;
      stg_we = '0; stg_is_load = '0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      step_t q[$];
      logic [5:0] e;
      use3 = 1'b0;
      q.push_back(mk(1, 5, 1, 0, 0, 5, 5, 5, 3'b111, 0, 0, 0, 1, 1, 0, 0, 0));
      q.push_back(mk(1, 5, 1, 0, 0, 5, 5, 5, 3'b111, 0, 0, 0, 1, 1, 0, 0, 0));
      foreach (q[i]) begin
         apply(q[i]);
         @(negedge clk);
         e = sbq.pop_front();
         n_checks++;
         if (o_vec !== e) begin
            n_fail++;
            $display("FAIL reset[%0d] got=%b exp=%b", i, o_vec, e);
         end else $display("reset[%0d] a/b/st/bu=%b", i, o_vec);
         @(posedge clk); #1;
      end
      n_checks++;
      if (o_scnt !== 32'd0 || o_fcnt !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_cnt got stall=%0d fwd=%0d exp 0/0", o_scnt, o_fcnt);
      end
   endtask

   task automatic test_forward();
      step_t q[$];
      logic [5:0] e;
      use3 = 1'b0;
      do_reset();
      q.push_back(mk(1, 5, 1, 0, 0, 5, 5, 5, 3'b111, 0, 0, 0, 0, 1, 0, 0, 0));
      q.push_back(mk(1, 5, 1, 0, 0, 5, 5, 3, 3'b111, 0, 0, 0, 0, 2, 0, 0, 0));
      q.push_back(mk(1, 5, 1, 0, 0, 5, 4, 5, 3'b110, 0, 0, 0, 0, 3, 0, 0, 0));
      q.push_back(mk(1, 5, 1, 9, 1, 9, 5, 5, 3'b111, 0, 0, 0, 0, 1, 3, 0, 0));
      q.push_back(mk(0, 5, 1, 9, 1, 9, 5, 5, 3'b111, 0, 0, 0, 0, 0, 0, 0, 0));
      foreach (q[i]) begin
         apply(q[i]);
         @(negedge clk);
         e = sbq.pop_front();
         n_checks++;
         if (o_vec !== e) begin
            n_fail++;
            $display("FAIL forward[%0d] got=%b exp=%b", i, o_vec, e);
         end else $display("forward[%0d] a/b/st/bu=%b", i, o_vec);
         @(posedge clk); #1;
      end
      n_checks++;
      if (o_fcnt !== 32'd4 || o_scnt !== 32'd0) begin
         n_fail++;
         $display("FAIL forward_cnt got fwd=%0d stall=%0d exp 4/0", o_fcnt, o_scnt);
      end
   endtask

   task automatic test_zero_unused();
      step_t q[$];
      logic [5:0] e;
      use3 = 1'b0;
      do_reset();
      q.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 3'b001, 3'b000, 0, 0, 0, 0, 0, 0, 0));
      q.push_back(mk(1, 0, 0, 7, 0, 0, 7, 0, 3'b010, 3'b000, 0, 0, 0, 0, 0, 0, 0));
      q.push_back(mk(1, 0, 0, 7, 1, 0, 7, 0, 3'b010, 3'b000, 0, 0, 0, 0, 2, 0, 0));
      q.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 3'b001, 3'b001, 0, 0, 0, 0, 0, 0, 0));
      foreach (q[i]) begin
         apply(q[i]);
         @(negedge clk);
         e = sbq.pop_front();
         n_checks++;
         if (o_vec !== e) begin
            n_fail++;
            $display("FAIL zero_unused[%0d] got=%b exp=%b", i, o_vec, e);
         end else $display("zero_unused[%0d] a/b/st/bu=%b", i, o_vec);
         @(posedge clk); #1;
      end
      n_checks++;
      if (o_fcnt !== 32'd1) begin
         n_fail++;
         $display("FAIL zero_unused_cnt got fwd=%0d exp 1", o_fcnt);
      end
   endtask

   task automatic test_load_lat1();
      step_t q[$];
      logic [5:0] e;
      use3 = 1'b0;
      do_reset();
      q.push_back(mk(1, 8, 1, 0, 0, 0, 0, 8, 3'b001, 3'b001, 0, 0, 0, 1, 0, 1, 1));
      q.push_back(mk(1, 8, 1, 0, 0, 0, 8, 0, 3'b010, 3'b010, 0, 0, 0, 2, 0, 0, 0));
      q.push_back(mk(0, 8, 1, 0, 0, 0, 8, 0, 3'b010, 3'b010, 0, 0, 0, 0, 0, 0, 0));
      foreach (q[i]) begin
         apply(q[i]);
         @(negedge clk);
         e = sbq.pop_front();
         n_checks++;
         if (o_vec !== e) begin
            n_fail++;
            $display("FAIL load_lat1[%0d] got=%b exp=%b", i, o_vec, e);
         end else $display("load_lat1[%0d] a/b/st/bu=%b", i, o_vec);
         @(posedge clk); #1;
      end
      n_checks++;
      if (o_scnt !== 32'd1 || o_fcnt !== 32'd1) begin
         n_fail++;
         $display("FAIL load_lat1_cnt got stall=%0d fwd=%0d exp 1/1", o_scnt, o_fcnt);
      end
   endtask

   task automatic test_back_to_back();
      step_t q[$];
      logic [5:0] e;
      use3 = 1'b0;
      do_reset();
      q.push_back(mk(1, 0, 0, 6, 1, 0, 6, 6, 3'b011, 3'b001, 0, 0, 0, 0, 1, 1, 1));
      q.push_back(mk(1, 0, 0, 6, 1, 0, 6, 6, 3'b011, 3'b001, 0, 0, 0, 0, 1, 1, 1));
      q.push_back(mk(1, 0, 0, 6, 1, 0, 6, 6, 3'b011, 3'b000, 0, 0, 0, 0, 1, 0, 0));
      q.push_back(mk(1, 0, 0, 6, 1, 0, 6, 6, 3'b011, 3'b001, 1, 0, 0, 0, 1, 0, 1));
      foreach (q[i]) begin
         apply(q[i]);
         @(negedge clk);
         e = sbq.pop_front();
         n_checks++;
         if (o_vec !== e) begin
            n_fail++;
            $display("FAIL back_to_back[%0d] got=%b exp=%b", i, o_vec, e);
         end else $display("back_to_back[%0d] a/b/st/bu=%b", i, o_vec);
         @(posedge clk); #1;
      end
      n_checks++;
      if (o_scnt !== 32'd2 || o_fcnt !== 32'd1) begin
         n_fail++;
         $display("FAIL back_to_back_cnt got stall=%0d fwd=%0d exp 2/1", o_scnt, o_fcnt);
      end
   endtask

   task automatic test_load_lat3();
      step_t q[$];
      logic [5:0] e;
      use3 = 1'b1;
      do_reset();
      q.push_back(mk(1, 8, 1, 0, 0, 0, 0, 8, 3'b001, 3'b001, 0, 0, 0, 1, 0, 1, 1));
      q.push_back(mk(1, 8, 1, 0, 0, 0, 0, 2, 3'b001, 3'b000, 0, 0, 0, 0, 0, 1, 1));
      q.push_back(mk(1, 8, 1, 0, 0, 0, 0, 2, 3'b001, 3'b000, 0, 0, 0, 0, 0, 1, 1));
      q.push_back(mk(1, 8, 1, 0, 0, 0, 0, 2, 3'b001, 3'b000, 0, 0, 0, 0, 0, 0, 0));
      foreach (q[i]) begin
         apply(q[i]);
         @(negedge clk);
         e = sbq.pop_front();
         n_checks++;
         if (o_vec !== e) begin
            n_fail++;
            $display("FAIL load_lat3[%0d] got=%b exp=%b", i, o_vec, e);
         end else $display("load_lat3[%0d] a/b/st/bu=%b", i, o_vec);
         @(posedge clk); #1;
      end
      n_checks++;
      if (o_scnt !== 32'd3) begin
         n_fail++;
         $display("FAIL load_lat3_cnt got stall=%0d exp 3", o_scnt);
      end
   endtask

   task automatic test_flush();
      step_t q[$];
      logic [5:0] e;
      use3 = 1'b1;
      do_reset();
      q.push_back(mk(1, 8, 1, 0, 0, 0, 0, 8, 3'b001, 3'b001, 0, 0, 0, 1, 0, 1, 1));
      q.push_back(mk(1, 8, 1, 0, 0, 0, 0, 2, 3'b001, 3'b000, 1, 0, 0, 0, 0, 0, 1));
      q.push_back(mk(1, 8, 1, 0, 0, 0, 0, 2, 3'b001, 3'b000, 0, 0, 0, 0, 0, 0, 0));
      foreach (q[i]) begin
         apply(q[i]);
         @(negedge clk);
         e = sbq.pop_front();
         n_checks++;
         if (o_vec !== e) begin
            n_fail++;
            $display("FAIL flush[%0d] got=%b exp=%b", i, o_vec, e);
         end else $display("flush[%0d] a/b/st/bu=%b", i, o_vec);
         @(posedge clk); #1;
      end
      n_checks++;
      if (o_scnt !== 32'd1) begin
         n_fail++;
         $display("FAIL flush_cnt got stall=%0d exp 1", o_scnt);
      end
   endtask

   task automatic test_saturate();
      step_t q[$];
      logic [5:0] e;
      use3 = 1'b1;
      do_reset();
      for (int i = 0; i < 18; i++)
         q.push_back(mk(1, 8, 1, 0, 0, 0, 0, 8, 3'b001, 3'b001, 0, 0, 0, 1, 0, 1, 1));
      q.push_back(mk(1, 8, 1, 0, 0, 0, 0, 8, 3'b001, 3'b001, 0, 1, 0, 1, 0, 1, 1));
      q.push_back(mk(1, 8, 1, 0, 0, 0, 0, 8, 3'b001, 3'b001, 0, 0, 0, 1, 0, 1, 1));
      foreach (q[i]) begin
         apply(q[i]);
         @(negedge clk);
         e = sbq.pop_front();
         n_checks++;
         if (o_vec !== e) begin
            n_fail++;
            $display("FAIL saturate[%0d] got=%b exp=%b", i, o_vec, e);
         end else $display("saturate[%0d] a/b/st/bu=%b cnt=%0d", i, o_vec, o_scnt);
         @(posedge clk); #1;
         if (i == 17) begin
            n_checks++;
            if (o_scnt !== 32'd15 || o_fcnt !== 32'd0) begin
               n_fail++;
               $display("FAIL saturate_hold got stall=%0d fwd=%0d exp 15/0", o_scnt, o_fcnt);
            end
         end else if (i == 18) begin
            n_checks++;
            if (o_scnt !== 32'd0) begin
               n_fail++;
               $display("FAIL saturate_clr got stall=%0d exp 0", o_scnt);
            end
         end else if (i == 19) begin
            n_checks++;
            if (o_scnt !== 32'd1) begin
               n_fail++;
               $display("FAIL saturate_after_clr got stall=%0d exp 1", o_scnt);
            end
         end
      end
   endtask

   task automatic test_reset_in_hold();
      step_t q[$];
      logic [5:0] e;
      use3 = 1'b1;
      do_reset();
      q.push_back(mk(1, 8, 1, 0, 0, 0, 0, 8, 3'b001, 3'b001, 0, 0, 0, 1, 0, 1, 1));
      q.push_back(mk(1, 8, 1, 0, 0, 0, 0, 2, 3'b001, 3'b000, 0, 0, 1, 0, 0, 1, 1));
      q.push_back(mk(1, 8, 1, 0, 0, 0, 0, 2, 3'b001, 3'b000, 0, 0, 0, 0, 0, 0, 0));
      foreach (q[i]) begin
         apply(q[i]);
         @(negedge clk);
         e = sbq.pop_front();
         n_checks++;
         if (o_vec !== e) begin
            n_fail++;
            $display("FAIL reset_in_hold[%0d] got=%b exp=%b", i, o_vec, e);
         end else $display("reset_in_hold[%0d] a/b/st/bu=%b", i, o_vec);
         @(posedge clk); #1;
      end
      n_checks++;
      if (o_scnt !== 32'd0 || o_fcnt !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_in_hold_cnt got stall=%0d fwd=%0d exp 0/0", o_scnt, o_fcnt);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_forward();
      test_zero_unused();
      test_load_lat1();
      test_back_to_back();
      test_load_lat3();
      test_flush();
      test_saturate();
      test_reset_in_hold();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/hazard_fwd_ctrl.md
Name: hazard_fwd_ctrl

Overview:
- Parametrised forwarding and hazard controller for the five-stage MIPS pipeline; next generation of the two-source (MEM/WB) forwarding unit.
- Tracks NSTG downstream writeback stages and selects the nearest valid producer per operand.
- Detects load-use hazards and holds a multi-cycle stall via a small FSM; supports pipeline flush.
- Keeps saturating stall/forward performance counters.
- Operand-use decode is done by the decoder, which supplies id_use_a/id_use_b; this block does no opcode decode.

Parameters:
- AW, 5: register address width.
- NSTG, 3: number of tracked producer stages. Index 0 is the nearest to ID (EX); higher indices are older.
- LOAD_LAT, 1: total stall cycles per load-use hazard. Must be ≥1.
- CNT_W, 32: performance counter width.
- SW, $clog2(NSTG+1): select width (derived).

Ports:
- clk, in, 1: clock.
- rst, in, 1: synchronous reset, active-high.
- id_valid, in, 1: valid instruction in ID.
- id_ra, in, AW: source A register.
- id_rb, in, AW: source B register.
- id_use_a, in, 1: instruction actually reads A.
- id_use_b, in, 1: instruction actually reads B.
- stg_rw, in, NSTG*AW: destination register per stage; stage k occupies bits [k*AW +: AW].
- stg_we, in, NSTG: regfile write enable per stage.
- stg_is_load, in, NSTG: stage holds a load.
- flush, in, 1: branch/jump flush of IF/ID.
- cnt_clr, in, 1: synchronous counter clear.
- fwd_a_sel, out, SW: 0 = regfile; k = forward from stage k-1.
- fwd_b_sel, out, SW: same encoding for operand B.
- stall, out, 1: hold PC and IF/ID.
- bubble, out, 1: insert NOP into ID/EX.
- stall_cnt, out, CNT_W: cycles with stall=1.
- fwd_cnt, out, CNT_W: issued instructions with at least one forwarded operand.

Behaviour:
- Match rule (operand X vs stage k): id_valid && id_use_X && stg_we[k] && stg_rw[k]==id_rX && id_rX!=0.
- Forward select:
  - Lowest matching k wins; sel = k+1.
  - No match → sel = 0.
  - sel is combinational and valid whenever stall=0.
- Load-use hazard: the winning match for A or B is stage 0 and stg_is_load[0]=1.
  - A load match at stage k≥1 forwards normally, since the data is available.
- FSM states: IDLE, HOLD. Internal counter rem is $clog2(LOAD_LAT+1) bits wide.
- IDLE:
  - Hazard && !flush → stall=1, bubble=1 in the same cycle (combinational).
  - If LOAD_LAT>1, go to HOLD next cycle with rem=LOAD_LAT-1; otherwise stay in IDLE.
- HOLD:
  - stall=1, bubble=1 unconditionally; stage inputs are ignored for the stall decision.
  - rem decrements each cycle. When rem==1, go to IDLE next cycle.
  - Total stall length is exactly LOAD_LAT cycles.
- Re-evaluation: on return to IDLE, hazard detection re-evaluates. A new hazard restarts the stall.
- Flush:
  - Forces stall=0 and bubble=1 combinationally.
  - FSM goes to IDLE next cycle, aborting HOLD.
  - Flush has priority over hazard.
- id_valid=0: both sels are 0, no hazard, stall=0 (unless in HOLD).
- Counters:
  - stall_cnt increments on each cycle with stall=1.
  - fwd_cnt increments on each cycle with id_valid && !stall && !flush && (fwd_a_sel!=0 || fwd_b_sel!=0).
  - Both saturate at all-ones.
  - Priority: rst > cnt_clr > increment. cnt_clr with a concurrent increment yields 0.
- Reset (synchronous): FSM=IDLE, rem=0, stall_cnt=0, fwd_cnt=0.
  - Combinational outputs follow inputs; stall=0 unless an IDLE hazard is present.
  - Reset in HOLD returns to IDLE next edge.
- Outputs contain no X for any input combination. Duplicate rw values across stages resolve by nearest stage.

Test Plan:
1. NSTG=3, id_ra=5, id_use_a=1, stg_rw={5,5,5}, we=3'b111, no loads → fwd_a_sel=1, stall=0, fwd_cnt +1 per cycle.
2. id_rb=0, stage 0 rw=0 we=1 → fwd_b_sel=0; id_use_b=0 with rb=7 matching stage 1 → fwd_b_sel=0.
3. LOAD_LAT=1: stage 0 load rw=8, id_ra=8 → stall=1, bubble=1 for exactly 1 cycle. Next cycle the load moves to stage 1 → fwd_a_sel=2, stall=0; stall_cnt=1.
4. LOAD_LAT=3: same hazard, with stage inputs changed to non-matching after cycle 1 → stall high exactly 3 cycles; stall_cnt=3.
5. LOAD_LAT=3: flush asserted in 2nd stall cycle → stall=0 that cycle, bubble=1, FSM IDLE next cycle; stall_cnt=1.
6. Counter preset near all-ones (CNT_W=4, 15 stall cycles, then more) → stall_cnt holds 15. cnt_clr with a concurrent stall → 0. rst during HOLD → IDLE, counters 0.
